pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor that generalises the team's fixed 64-bit combinational CLA. Operands enter through a valid/ready handshake. The carry chain is split into `STAGES` registered segments, each built from `BLOCK`-bit lookahead groups. Results leave through a second valid/ready handshake with full backpressure. The block sits in the datapath wherever a wide add must close timing at high clock rates and sustain one operation per cycle.

## Interface
Parameters:
- `WIDTH` — default 64 — operand and result width. Must be a multiple of `STAGES * BLOCK`.
- `STAGES` — default 4 — pipeline depth. Each stage owns `SEG = WIDTH/STAGES` result bits.
- `BLOCK` — default 4 — CLA group size within a segment (group P/G, then segment-level lookahead).

Ports:
- `clk` — in — 1 — single clock; all state updates on the rising edge.
- `rst_n` — in — 1 — reset, asynchronous and active-low.
- `in_valid` — in — 1 — operand bundle valid.
- `in_ready` — out — 1 — block accepts the bundle this cycle.
- `in_a` — in — WIDTH — operand A.
- `in_b` — in — WIDTH — operand B.
- `in_cin` — in — 1 — carry-in for add; borrow-in for subtract.
- `in_sub` — in — 1 — 0 = add, 1 = subtract.
- `out_valid` — out — 1 — result valid.
- `out_ready` — in — 1 — downstream accepts the result.
- `out_sum` — out — WIDTH — result.
- `out_cout` — out — 1 — raw carry out of the MSB. For subtract, 1 means no borrow.
- `out_ovf` — out — 1 — two's-complement signed overflow.
- `out_zero` — out — 1 — `out_sum == 0`.

## Operation
- **Operand conditioning at accept:**
  - `b_eff = in_sub ? ~in_b : in_b`
  - `c_eff = in_sub ? ~in_cin : in_cin`
  - Subtract therefore computes A − B − in_cin.
- **Stage k (0 … STAGES−1):**
  - Adds bits `[k*SEG +: SEG]` of A and `b_eff`, using the carry registered by stage k−1 (`c_eff` for stage 0).
  - Registers its SEG sum bits and its carry-out.
- **Skew registers:**
  - Unconsumed upper operand bits travel forward with the stage.
  - Completed lower sum bits travel forward with the stage.
  - All results are fully aligned at the last stage.
- **Within a segment:**
  - Group generate/propagate: `g = a & b`, `p = a ^ b`.
  - Group carries come from lookahead across `SEG/BLOCK` groups. No ripple across groups.
  - `sum = p ^ carry`.
- **Flags, computed in the final stage:**
  - `out_ovf = carry_into_MSB ^ carry_out_of_MSB`
  - `out_zero = ~|sum`
- **Valid tracking:** one valid bit per stage. Bubbles are carried, not collapsed.
- **Global stall:**
  - `advance = !out_valid || out_ready`
  - `in_ready = advance` (0 while `rst_n` is low).
  - When `advance` is 0, every stage register and valid bit holds.
- Accept occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Results emerge strictly in acceptance order. None is dropped or duplicated.

## Timing
- **Reset (asynchronous assert, synchronous release on the next edge):**
  - All stage valid bits are 0; all data registers are 0.
  - `out_valid = 0`, `out_sum = 0`, `out_cout = 0`, `out_ovf = 0`, `out_zero = 0`.
- **Latency:** a bundle accepted at edge N appears on the outputs with `out_valid = 1` after edge N+STAGES, provided there is no stall.
- **Throughput:** one result per cycle while `out_ready = 1`.
- **Stall:**
  - `out_valid && !out_ready` drops `in_ready` combinationally in the same cycle.
  - The pipeline resumes on the first cycle `out_ready` returns to 1.
  - Outputs stay stable while stalled.
- **Simultaneous accept and output transfer:** both occur in the same cycle.
- **Reset asserted mid-stream:**
  - All in-flight operations are discarded immediately.
  - `out_valid` falls asynchronously.
- **Carry crossing all segments** (e.g. all-ones + 1) must still produce the correct result at latency STAGES. The carry is registered at each boundary.
- **Outputs are registered.** The combinational paths to outputs are only `in_ready` (from `out_valid`/`out_ready`).

## Test plan
All scenarios use WIDTH=64, STAGES=4, BLOCK=4 unless noted.
- **Add:** a=0x1234567890000000, b=0x00AABBCCDDEEFF11, sub=0, cin=0 → sum=0x12DF12456DEEFF11, cout=0, ovf=0, zero=0. `out_valid` rises exactly 4 cycles after accept.
- **Full carry propagation:** a=0xFFFFFFFFFFFFFFFF, b=0, cin=1 → sum=0, cout=1, zero=1, ovf=0. Repeat with WIDTH=32, STAGES=2 → same flags, latency 2.
- **Subtract:** a=0x5233458, b=0x4578213, sub=1, cin=0 → sum=0x0000000000CBB245, cout=1. Also a=0, b=1, sub=1 → sum=0xFFFFFFFFFFFFFFFF, cout=0.
- **Overflow:** a=0x7FFFFFFFFFFFFFFF, b=1, add → sum=0x8000000000000000, ovf=1, cout=0.
- **Streaming and backpressure:** 8 back-to-back random ops, with `out_ready` held low for 5 cycles mid-stream.
  - `in_ready` is low exactly while `out_valid && !out_ready`.
  - All 8 results match a reference model, in order, with no loss or duplication.
- **Reset mid-stream:** assert `rst_n=0` with 3 ops in flight.
  - `out_valid=0` and all outputs are 0 immediately.
  - After release, no stale result ever appears.
  - The next accepted op completes with latency 4.

Source files
------------

// File: rtl/pipelined_cla_adder_if.sv
// Operand and result handshake bundle for pipelined_cla_adder.
// The master drives operands and out_ready; the slave (the adder) drives in_ready and results.
interface pipelined_cla_adder_if #(
   parameter int WIDTH = 64
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );

endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one SEG-bit segment with
// BLOCK-bit lookahead groups and hands its carry to the next stage through a register.
module pipelined_cla_adder #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4,
   parameter int BLOCK  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipelined_cla_adder_if.slave bus
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int NG   = SEG / BLOCK;
   localparam int LAST = STAGES - 1;

   typedef logic [WIDTH-1:0] word_t;

   // Carry into position n as a flat sum of products over g/p, never a ripple chain.
   function automatic logic la_carry(input logic [SEG-1:0] g, input logic [SEG-1:0] p,
                                     input logic cin, input int n);
      logic c;
      logic term;
      c = cin;
      for (int m = 0; m < n; m++) c = c & p[m];
      for (int i = 0; i < n; i++) begin
         term = g[i];
         for (int m = i + 1; m < n; m++) term = term & p[m];
         c = c | term;
      end
      return c;
   endfunction

   // Returns every bit carry of a segment: bit i is the carry into bit i, bit SEG the carry out.
   function automatic logic [SEG:0] seg_carries(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                                input logic cin);
      logic [SEG-1:0] g;
      logic [SEG-1:0] p;
      logic [SEG-1:0] grp_g;
      logic [SEG-1:0] grp_p;
      logic [NG:0]    grp_c;
      logic [SEG:0]   c;
      g     = a & b;
      p     = a ^ b;
      grp_g = '0;
      grp_p = '0;
      c     = '0;
      for (int j = 0; j < NG; j++) begin
         grp_p[j] = &p[j*BLOCK +: BLOCK];
         grp_g[j] = la_carry(g >> (j*BLOCK), p >> (j*BLOCK), 1'b0, BLOCK);
      end
      for (int j = 0; j <= NG; j++) grp_c[j] = la_carry(grp_g, grp_p, cin, j);
      for (int j = 0; j < NG; j++) begin
         for (int t = 0; t < BLOCK; t++) begin
            c[j*BLOCK + t] = la_carry(g >> (j*BLOCK), p >> (j*BLOCK), grp_c[j], t);
         end
      end
      c[SEG] = grp_c[NG];
      return c;
   endfunction

   // Rank k holds what stage k consumes; operands shift down so the live segment sits at bit 0.
   word_t           opa_q [STAGES];
   word_t           opb_q [STAGES];
   logic            cy_q  [STAGES];
   word_t           sum_q [STAGES];
   logic [STAGES:0] vld_q;
   logic            cout_q;
   logic            ovf_q;
   logic            zero_q;
   logic            advance;
   logic            accept;

   assign advance      = !vld_q[STAGES] || bus.out_ready;
   assign bus.in_ready = advance && rst_n;
   assign accept       = bus.in_valid && bus.in_ready;

   // Operand conditioning happens here so that subtract is just an add of ~B with inverted carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q    <= '0;
         opa_q[0] <= '0;
         opb_q[0] <= '0;
         cy_q[0]  <= 1'b0;
      end else if (advance) begin
         vld_q    <= {vld_q[STAGES-1:0], accept};
         opa_q[0] <= bus.in_a;
         opb_q[0] <= bus.in_sub ? ~bus.in_b : bus.in_b;
         cy_q[0]  <= bus.in_cin ^ bus.in_sub;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SEG:0]   seg_c;
      logic [SEG-1:0] seg_s;
      word_t          sum_d;

      always_comb begin
         seg_c = seg_carries(opa_q[k][SEG-1:0], opb_q[k][SEG-1:0], cy_q[k]);
         seg_s = opa_q[k][SEG-1:0] ^ opb_q[k][SEG-1:0] ^ seg_c[SEG-1:0];
      end

      // Finished sum bits enter at the top and slide down, landing aligned after the last stage.
      if (k == 0) begin : g_head
         always_comb sum_d = word_t'(seg_s) << (WIDTH - SEG);
      end else begin : g_body
         always_comb sum_d = (sum_q[k-1] >> SEG) | (word_t'(seg_s) << (WIDTH - SEG));
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sum_q[k] <= '0;
         end else if (advance) begin
            sum_q[k] <= sum_d;
         end
      end

      if (k < LAST) begin : g_fwd
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               opa_q[k+1] <= '0;
               opb_q[k+1] <= '0;
               cy_q[k+1]  <= 1'b0;
            end else if (advance) begin
               opa_q[k+1] <= opa_q[k] >> SEG;
               opb_q[k+1] <= opb_q[k] >> SEG;
               cy_q[k+1]  <= seg_c[SEG];
            end
         end
      end else begin : g_tail
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cout_q <= 1'b0;
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (advance) begin
               cout_q <= seg_c[SEG];
               ovf_q  <= seg_c[SEG] ^ seg_c[SEG-1];
               zero_q <= ~|sum_d;
            end
         end
      end
   end

   assign bus.out_valid = vld_q[STAGES];
   assign bus.out_sum   = sum_q[LAST];
   assign bus.out_cout  = cout_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: a cycle model of the valid pipeline plus a queue
// of hand-computed results, checked by a monitor independent of the stimulus.
module tb_pipelined_cla_adder;

   localparam int S64 = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   pipelined_cla_adder_if #(.WIDTH(64)) bus64 ();
   pipelined_cla_adder_if #(.WIDTH(32)) bus32 ();

   pipelined_cla_adder #(.WIDTH(64), .STAGES(4), .BLOCK(4)) dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus64.slave)
   );

   pipelined_cla_adder #(.WIDTH(32), .STAGES(2), .BLOCK(4)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32.slave)
   );

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   exp_t        sbq [$];
   int          nCompares = 0;
   int          nFail     = 0;
   logic [S64:0] mVld;
   logic        mExpReady;
   bit          acceptFlag;
   exp_t        mHead;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      nCompares++;
      if (act !== req) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic req);
      nCompares++;
      if (act !== req) begin
         nFail++;
         $display("[TB] FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   // Monitor: advances the reference valid pipeline and compares whatever sits at the output.
   always @(negedge clk) begin
      if (!rst_n) begin
         mVld       = '0;
         acceptFlag = 1'b0;
      end else begin
         mExpReady = !mVld[S64] || bus64.out_ready;
         checkBit("in_ready", bus64.in_ready, mExpReady);
         checkBit("out_valid", bus64.out_valid, mVld[S64]);
         if (mVld[S64]) begin
            if (sbq.size() == 0) begin
               nCompares++;
               nFail++;
               $display("[TB] FAIL unexpected_result: got sum %h, required no pending result", bus64.out_sum);
            end else begin
               mHead = sbq[0];
               checkOutput("out_sum", bus64.out_sum, mHead.sum);
               checkBit("out_cout", bus64.out_cout, mHead.cout);
               checkBit("out_ovf", bus64.out_ovf, mHead.ovf);
               checkBit("out_zero", bus64.out_zero, mHead.zero);
               if (bus64.out_ready) void'(sbq.pop_front());
            end
         end
         acceptFlag = bus64.in_valid && mExpReady;
         if (mExpReady) mVld = {mVld[S64-1:0], acceptFlag};
      end
   end

   // Called at posedge+2; holds the bundle until the model says it was taken.
   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                input logic sub, input logic [63:0] esum, input logic ecout,
                                input logic eovf, input logic ezero);
      bit done;
      done = 1'b0;
      bus64.in_a     = a;
      bus64.in_b     = b;
      bus64.in_cin   = cin;
      bus64.in_sub   = sub;
      bus64.in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         #1;
         if (acceptFlag) begin
            done = 1'b1;
            sbq.push_back('{sum: esum, cout: ecout, ovf: eovf, zero: ezero});
         end
         @(posedge clk);
         #2;
      end
      bus64.in_valid = 1'b0;
      checkBit("accept", done, 1'b1);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 60 && sbq.size() != 0; i++) begin
         @(posedge clk);
         #2;
      end
      checkOutput("drain", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int  lat;
      bit  got;
      rst_n           = 1'b0;
      bus64.in_valid  = 1'b0;
      bus64.in_a      = '0;
      bus64.in_b      = '0;
      bus64.in_cin    = 1'b0;
      bus64.in_sub    = 1'b0;
      bus64.out_ready = 1'b1;
      bus32.in_valid  = 1'b0;
      bus32.in_a      = '0;
      bus32.in_b      = '0;
      bus32.in_cin    = 1'b0;
      bus32.in_sub    = 1'b0;
      bus32.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #2;
      checkBit("rst_out_valid", bus64.out_valid, 1'b0);
      checkBit("rst_in_ready", bus64.in_ready, 1'b0);
      checkOutput("rst_out_sum", bus64.out_sum, 64'd0);
      checkBit("rst_out_cout", bus64.out_cout, 1'b0);
      checkBit("rst_out_ovf", bus64.out_ovf, 1'b0);
      checkBit("rst_out_zero", bus64.out_zero, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      $display("[TB] directed single operations");
      applyStimulus(64'h1234567890000000, 64'h00AABBCCDDEEFF11, 1'b0, 1'b0,
                    64'h12DF12456DEEFF11, 1'b0, 1'b0, 1'b0);
      waitDrain();
      applyStimulus(64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b0,
                    64'h0, 1'b1, 1'b0, 1'b1);
      waitDrain();
      applyStimulus(64'h5233458, 64'h4578213, 1'b0, 1'b1,
                    64'h0000000000CBB245, 1'b1, 1'b0, 1'b0);
      waitDrain();
      applyStimulus(64'h0, 64'h1, 1'b0, 1'b1,
                    64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0);
      waitDrain();
      applyStimulus(64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0,
                    64'h8000000000000000, 1'b0, 1'b1, 1'b0);
      waitDrain();

      $display("[TB] streaming with backpressure");
      fork
         begin
            applyStimulus(64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0, 1'b0);
            applyStimulus(64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b0,
                          64'h0, 1'b1, 1'b1, 1'b1);
            applyStimulus(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0,
                          64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0);
            applyStimulus(64'd10, 64'd3, 1'b0, 1'b1, 64'd7, 1'b1, 1'b0, 1'b0);
            applyStimulus(64'd5, 64'd5, 1'b1, 1'b1,
                          64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0);
            applyStimulus(64'h8000000000000000, 64'h1, 1'b0, 1'b1,
                          64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b0);
            applyStimulus(64'h00000000FFFFFFFF, 64'h1, 1'b0, 1'b0,
                          64'h0000000100000000, 1'b0, 1'b0, 1'b0);
            applyStimulus(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1, 1'b0,
                          64'h0, 1'b1, 1'b0, 1'b1);
         end
         begin
            repeat (6) @(posedge clk);
            #2;
            bus64.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #2;
            bus64.out_ready = 1'b1;
         end
      join
      waitDrain();

      $display("[TB] reset with operations in flight");
      bus64.out_ready = 1'b0;
      applyStimulus(64'h1234567890000000, 64'h00AABBCCDDEEFF11, 1'b0, 1'b0,
                    64'h12DF12456DEEFF11, 1'b0, 1'b0, 1'b0);
      applyStimulus(64'd10, 64'd3, 1'b0, 1'b1, 64'd7, 1'b1, 1'b0, 1'b0);
      applyStimulus(64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkBit("midrst_out_valid", bus64.out_valid, 1'b0);
      checkBit("midrst_in_ready", bus64.in_ready, 1'b0);
      checkOutput("midrst_out_sum", bus64.out_sum, 64'd0);
      checkBit("midrst_out_cout", bus64.out_cout, 1'b0);
      checkBit("midrst_out_ovf", bus64.out_ovf, 1'b0);
      checkBit("midrst_out_zero", bus64.out_zero, 1'b0);
      sbq.delete();
      bus64.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      applyStimulus(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 1'b0,
                    64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0);
      waitDrain();
      repeat (6) @(posedge clk);
      #2;

      $display("[TB] 32-bit two-stage carry crossing");
      bus32.in_a     = 32'hFFFFFFFF;
      bus32.in_b     = 32'h0;
      bus32.in_cin   = 1'b1;
      bus32.in_sub   = 1'b0;
      bus32.in_valid = 1'b1;
      @(negedge clk);
      checkBit("w32_in_ready", bus32.in_ready, 1'b1);
      @(posedge clk);
      #1;
      bus32.in_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus32.out_valid) got = 1'b1;
      end
      checkOutput("w32_latency", 64'(lat), 64'd2);
      checkOutput("w32_out_sum", 64'(bus32.out_sum), 64'd0);
      checkBit("w32_out_cout", bus32.out_cout, 1'b1);
      checkBit("w32_out_ovf", bus32.out_ovf, 1'b0);
      checkBit("w32_out_zero", bus32.out_zero, 1'b1);

      waitDrain();
      $display("== %0d vectors applied, %0d miscompares ==", nCompares, nFail);
      $finish;
   end

endmodule
